// File: rtl/calc_pkg.sv
// Shared types for the calculator keypad front end: command codes,
// calc_top status encodings, keypad FSM states and the key-to-command map.
package calc_pkg;

  typedef logic [3:0] cmd_t;

  typedef enum logic [1:0] {
    READY = 2'd0,
    OK    = 2'd1,
    BUSY  = 2'd2,
    ERROR = 2'd3
  } status_t;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    WAIT_RELEASE
  } kp_state_t;

  localparam cmd_t CMD_ADD = 4'hA;
  localparam cmd_t CMD_SUB = 4'hB;
  localparam cmd_t CMD_MUL = 4'hC;
  localparam cmd_t CMD_DIV = 4'hD;
  localparam cmd_t CMD_CLR = 4'hE;
  localparam cmd_t CMD_EQU = 4'hF;

  // Indexed by {row_idx, col_idx}; phone-style layout.
  localparam cmd_t KEYMAP [16] = '{
    4'h1,    4'h2, 4'h3,    CMD_ADD,
    4'h4,    4'h5, 4'h6,    CMD_SUB,
    4'h7,    4'h8, 4'h9,    CMD_MUL,
    CMD_CLR, 4'h0, CMD_EQU, CMD_DIV
  };

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0) && ((v & (v - 4'b1)) == 4'b0);
  endfunction

  // Only meaningful for a one-hot argument.
  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    unique case (1'b1)
      v[0]: r = 2'd0;
      v[1]: r = 2'd1;
      v[2]: r = 2'd2;
      v[3]: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/calc_row_sync.sv
// Two-flop synchroniser for the raw keypad row inputs.
// Clears to zero on reset.
module calc_row_sync #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  // Metastability chain: raw rows in, stable rows out two cycles later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/calc_keypad.sv
// 4x4 keypad scanner/debouncer feeding calc_top.cmd with one strobe per press.
// Define CALC_KEYPAD_REPEAT_EN to build the held-key auto-repeat.
module calc_keypad
  import calc_pkg::*;
#(
  parameter int   SCAN_DIV      = 1000,
  parameter int   DEB_CYCLES    = 20000,
  parameter cmd_t IDLE_CMD      = 4'hF,
  parameter int   REPEAT_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic [1:0] status,
  output logic [3:0] col,
  output logic [3:0] cmd,
  output logic       cmd_valid
);

  localparam int CNT_MAX = (SCAN_DIV > DEB_CYCLES) ? SCAN_DIV : DEB_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);

  // The last-cycle row sample must see this column, not the previous one.
  if (SCAN_DIV < 3 || DEB_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_param_chk
    $error("calc_keypad: SCAN_DIV>=3, DEB_CYCLES>=1, REPEAT_CYCLES>=2");
  end

  logic [3:0]    row_s;
  kp_state_t     state_q;
  logic [3:0]    col_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    row_idx_q;
  logic [1:0]    col_idx_q;
  cmd_t          cmd_q;
  logic          valid_q;
  logic [3:0]    key_row;
  logic [3:0]    col_next;

  calc_row_sync #(.W(4)) u_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (row),
    .q_o   (row_s)
  );

  assign key_row  = 4'b0001 << row_idx_q;
  assign col_next = {col_q[2:0], col_q[3]};

`ifdef CALC_KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_q;
`endif

  // Keypad FSM: scan, debounce press, emit strobe, debounce release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= SCAN;
      col_q     <= 4'b0001;
      cnt_q     <= '0;
      row_idx_q <= 2'd0;
      col_idx_q <= 2'd0;
      cmd_q     <= IDLE_CMD;
      valid_q   <= 1'b0;
`ifdef CALC_KEYPAD_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      cmd_q   <= IDLE_CMD;
      unique case (state_q)
        SCAN: begin
          if (cnt_q == SCAN_LAST) begin
            cnt_q <= '0;
            if (is_onehot4(row_s)) begin
              row_idx_q <= enc4(row_s);
              col_idx_q <= enc4(col_q);
              state_q   <= DEBOUNCE;
            end else begin
              col_q <= col_next;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (row_s != key_row) begin
            state_q <= SCAN;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= EMIT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        EMIT: begin
          if (status != BUSY) begin
            valid_q <= 1'b1;
            cmd_q   <= KEYMAP[{row_idx_q, col_idx_q}];
            state_q <= WAIT_RELEASE;
            cnt_q   <= '0;
`ifdef CALC_KEYPAD_REPEAT_EN
            // The EMIT cycle counts toward the repeat period.
            rep_q   <= RW'(1);
`endif
          end
        end
        WAIT_RELEASE: begin
          if (row_s != 4'b0) begin
            cnt_q <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= SCAN;
            cnt_q   <= '0;
            col_q   <= col_next;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`ifdef CALC_KEYPAD_REPEAT_EN
          if (row_s == key_row) begin
            if (rep_q >= REP_LAST) begin
              state_q <= EMIT;
              rep_q   <= '0;
            end else begin
              rep_q <= rep_q + 1'b1;
            end
          end else begin
            rep_q <= '0;
          end
`endif
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign col       = col_q;
  assign cmd       = cmd_q;
  assign cmd_valid = valid_q;

endmodule
